modulo_reconstruct_seq: RTL and testbench

- Sequential inverse of the modulo reducers. Takes a (quotient, remainder) pair for a fixed MODULUS and rebuilds data = quotient*MODULUS + remainder.
- Uses one shift-add step per quotient bit, with valid/ready handshakes on both sides.
- Sits beside modulo_naive/modulo_barrett in the mux library. Used for round-trip checking and for index-to-address expansion.

---
 rtl/modulo_reconstruct_seq.sv | 137 +++++++++++++
 tb/tb_modulo_reconstruct_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/modulo_reconstruct_seq.sv
// Sequential inverse of the modulo reducers: rebuilds quot*MODULUS + rem
// with one shift-add step per quotient bit, valid/ready on both sides.
module modulo_reconstruct_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int MODULUS    = 7
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  input  logic [DATA_WIDTH-1:0]            quot_i,
  input  logic [$clog2(MODULUS)-1:0]       rem_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [DATA_WIDTH-1:0]            data_o,
  output logic                             overflow_o,
  output logic                             rem_err_o
);

  // state | meaning
  // IDLE  | waiting for a quotient/remainder pair
  // BUSY  | one shift-add step per quotient bit, LSB first
  // DONE  | result presented until the downstream takes it

  localparam int REM_WIDTH = $clog2(MODULUS);
  localparam int ACC_WIDTH = DATA_WIDTH + REM_WIDTH + 1;
  localparam int CNT_WIDTH = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [ACC_WIDTH-1:0] MOD_ACC  = ACC_WIDTH'(MODULUS);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   quot_q, quot_d;
  logic [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic [ACC_WIDTH-1:0]    addend_q, addend_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    rem_flag_q, rem_flag_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    overflow_q, overflow_d;
  logic                    rem_err_q, rem_err_d;
  logic [ACC_WIDTH-1:0]    rem_ext;
  logic [ACC_WIDTH-1:0]    acc_step;

  assign rem_ext  = {{(ACC_WIDTH-REM_WIDTH){1'b0}}, rem_i};
  assign acc_step = acc_q + (quot_q[0] ? addend_q : {ACC_WIDTH{1'b0}});

  always_comb begin
    state_d     = state_q;
    quot_d      = quot_q;
    acc_d       = acc_q;
    addend_d    = addend_q;
    cnt_d       = cnt_q;
    rem_flag_d  = rem_flag_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    data_d      = data_q;
    overflow_d  = overflow_q;
    rem_err_d   = rem_err_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i && in_ready_q) begin
          quot_d     = quot_i;
          acc_d      = rem_ext;
          addend_d   = MOD_ACC;
          rem_flag_d = (rem_ext >= MOD_ACC);
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        acc_d    = acc_step;
        addend_d = addend_q << 1;
        quot_d   = quot_q >> 1;
        cnt_d    = cnt_q + CNT_WIDTH'(1);
        // Result registers load on the last step so they are valid with out_valid.
        if (cnt_q == CNT_LAST) begin
          data_d      = acc_step[DATA_WIDTH-1:0];
          overflow_d  = |acc_step[ACC_WIDTH-1:DATA_WIDTH];
          rem_err_d   = rem_flag_q;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      quot_q      <= '0;
      acc_q       <= '0;
      addend_q    <= '0;
      cnt_q       <= '0;
      rem_flag_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      overflow_q  <= 1'b0;
      rem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      quot_q      <= quot_d;
      acc_q       <= acc_d;
      addend_q    <= addend_d;
      cnt_q       <= cnt_d;
      rem_flag_q  <= rem_flag_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      overflow_q  <= overflow_d;
      rem_err_q   <= rem_err_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign data_o      = data_q;
  assign overflow_o  = overflow_q;
  assign rem_err_o   = rem_err_q;

endmodule

// File: tb/tb_modulo_reconstruct_seq.sv
// Directed and random round-trip bench for modulo_reconstruct_seq (8-bit, modulus 7).
module tb_modulo_reconstruct_seq;

  localparam int DW  = 8;
  localparam int MOD = 7;
  localparam int RW  = $clog2(MOD);

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [DW-1:0] quot_i;
  logic [RW-1:0] rem_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [DW-1:0] data_o;
  logic          overflow_o;
  logic          rem_err_o;

  int n_checks = 0;
  int n_errors = 0;

  modulo_reconstruct_seq #(.DATA_WIDTH(DW), .MODULUS(MOD)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .quot_i      (quot_i),
    .rem_i       (rem_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .data_o      (data_o),
    .overflow_o  (overflow_o),
    .rem_err_o   (rem_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Accept one pair with out_ready held high; check latency, result and return to idle.
  task automatic run_op(input int q, input int r, input int exp_data, input int exp_ovf,
                        input int exp_err);
    int wait_n;
    int lat;
    wait_n = 0;
    while (!in_ready_o && wait_n < 40) begin
      tick();
      wait_n++;
    end
    check("ready_before_accept", 32'(in_ready_o), 1);
    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    quot_i      = DW'(q);
    rem_i       = RW'(r);
    tick();
    in_valid_i  = 1'b0;
    check("busy_in_ready", 32'(in_ready_o), 0);
    lat = 0;
    while (!out_valid_o && lat < 40) begin
      tick();
      lat++;
    end
    check("latency", 32'(lat), DW);
    check("data", 32'(data_o), 32'(exp_data));
    check("overflow", 32'(overflow_o), 32'(exp_ovf));
    check("rem_err", 32'(rem_err_o), 32'(exp_err));
    check("done_in_ready", 32'(in_ready_o), 0);
    tick();
    check("idle_out_valid", 32'(out_valid_o), 0);
    check("idle_in_ready", 32'(in_ready_o), 1);
  endtask

  initial begin
    int lat;
    int got;
    int d;
    int wait_n;

    rst_i       = 1'b1;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    quot_i      = '0;
    rem_i       = '0;
    tick();
    tick();
    rst_i = 1'b0;
    check("rst_in_ready", 32'(in_ready_o), 1);
    check("rst_out_valid", 32'(out_valid_o), 0);
    check("rst_data", 32'(data_o), 0);

    run_op(10, 3, 73, 0, 0);
    run_op(36, 3, 255, 0, 0);
    run_op(36, 4, 0, 1, 0);
    run_op(0, 7, 7, 0, 1);
    run_op(255, 6, 255, 1, 0);

    // Backpressure: result must hold while a different pair waits upstream.
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    quot_i      = 8'd5;
    rem_i       = 3'd2;
    tick();
    quot_i = 8'd1;
    rem_i  = 3'd1;
    lat = 0;
    while (!out_valid_o && lat < 40) begin
      tick();
      lat++;
    end
    check("bp_latency", 32'(lat), DW);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", 32'(out_valid_o), 1);
      check("bp_data", 32'(data_o), 37);
      check("bp_in_ready", 32'(in_ready_o), 0);
      tick();
    end
    out_ready_i = 1'b1;
    tick();
    check("bp_release_valid", 32'(out_valid_o), 0);
    check("bp_release_ready", 32'(in_ready_o), 1);
    tick();
    in_valid_i = 1'b0;
    check("bp_next_accepted", 32'(in_ready_o), 0);
    lat = 0;
    while (!out_valid_o && lat < 40) begin
      tick();
      lat++;
    end
    check("bp_next_data", 32'(data_o), 8);
    tick();

    // Reset on the 4th BUSY edge abandons the operation.
    in_valid_i = 1'b1;
    quot_i     = 8'd20;
    rem_i      = 3'd1;
    tick();
    in_valid_i = 1'b0;
    tick();
    tick();
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("mid_rst_in_ready", 32'(in_ready_o), 1);
    check("mid_rst_out_valid", 32'(out_valid_o), 0);
    check("mid_rst_data", 32'(data_o), 0);
    check("mid_rst_ovf", 32'(overflow_o), 0);
    check("mid_rst_err", 32'(rem_err_o), 0);
    for (int i = 0; i < DW + 2; i++) begin
      check("mid_rst_no_output", 32'(out_valid_o), 0);
      tick();
    end
    run_op(3, 0, 21, 0, 0);

    // Random round-trip with throttled valid/ready.
    for (int v = 0; v < 2000; v++) begin
      d = $urandom_range(0, 255);
      out_ready_i = 1'b0;
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
      in_valid_i = 1'b1;
      quot_i     = DW'(d / MOD);
      rem_i      = RW'(d % MOD);
      wait_n = 0;
      while (!in_ready_o && wait_n < 40) begin
        tick();
        wait_n++;
      end
      tick();
      in_valid_i = 1'b0;
      got = 0;
      for (int k = 0; k < 80 && got == 0; k++) begin
        out_ready_i = 1'($urandom_range(0, 1));
        if (out_valid_o && out_ready_i) begin
          check("rt_data", 32'(data_o), 32'(d));
          check("rt_ovf", 32'(overflow_o), 0);
          check("rt_err", 32'(rem_err_o), 0);
          got = 1;
        end
        tick();
      end
      check("rt_result_seen", 32'(got), 1);
    end
    out_ready_i = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
